// File: rtl/bsg_manycore_vcache_trace_pkg.sv
// Shared types for the vcache trace replayer: trace ops, replay states, cache opcodes,
// plus struct-declaration macros sized by the instantiating module's parameters.
package bsg_manycore_vcache_trace_pkg;

    typedef enum logic [1:0] {
        eNop    = 2'd0,
        eSM     = 2'd1,
        eLM     = 2'd2,
        eFinish = 2'd3
    } trace_op_e;

    typedef enum logic [1:0] {
        eRun   = 2'd0,
        eDrain = 2'd1,
        eDone  = 2'd2
    } replay_state_e;

    // Word load/store opcodes as encoded by bsg_cache.
    typedef enum logic [5:0] {
        eCacheLW = 6'h02,
        eCacheSW = 6'h0A
    } cache_opcode_e;

endpackage

`ifndef BSG_MANYCORE_VCACHE_TRACE_MACROS
`define BSG_MANYCORE_VCACHE_TRACE_MACROS

`define DECLARE_TRACE_ENTRY_S(addr_w, data_w) \
    typedef struct packed { \
        bsg_manycore_vcache_trace_pkg::trace_op_e op; \
        logic [addr_w-1:0] addr; \
        logic [data_w-1:0] data; \
    } trace_entry_s

`define DECLARE_BSG_CACHE_PKT_S(addr_w, data_w) \
    typedef struct packed { \
        bsg_manycore_vcache_trace_pkg::cache_opcode_e opcode; \
        logic [addr_w-1:0] addr; \
        logic [data_w-1:0] data; \
        logic [(data_w/8)-1:0] mask; \
    } bsg_cache_pkt_s

`define BSG_CACHE_PKT_WIDTH(addr_w, data_w) (6 + (addr_w) + (data_w) + ((data_w) / 8))

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with valid/ready enqueue and valid/yumi dequeue; no enq/deq bypass,
// so a full FIFO refuses enqueue even when it is being popped in the same cycle.
module bsg_fifo_1r1w_small #(
    parameter int els_p   = 4,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] rptr_q, wptr_q;
    logic [cnt_width_lp-1:0] cnt_q;
    logic                    enq, deq;

    assign ready_o = (cnt_q != cnt_width_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq) wptr_q <= next_ptr(wptr_q);
            if (deq) rptr_q <= next_ptr(rptr_q);
            if (enq && !deq) cnt_q <= cnt_q + 1'b1;
            else if (!enq && deq) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_vcache_trace_replayer.sv
// Replays SM/LM trace entries into a bsg_cache packet port and checks LM responses
// in order against the recorded data, counting mismatches until FINISH drains.
module bsg_manycore_vcache_trace_replayer
    import bsg_manycore_vcache_trace_pkg::*;
#(
    parameter int addr_width_p  = 12,
    parameter int data_width_p  = 32,
    parameter int max_out_p     = 4,
    parameter int count_width_p = 32,
    localparam int entry_width_lp = 2 + addr_width_p + data_width_p,
    localparam int pkt_width_lp   = `BSG_CACHE_PKT_WIDTH(addr_width_p, data_width_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [entry_width_lp-1:0] trace_entry_i,
    input  logic                      trace_v_i,
    output logic                      trace_ready_o,
    output logic [pkt_width_lp-1:0]   cache_pkt_o,
    output logic                      v_o,
    input  logic                      ready_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic                      v_i,
    output logic                      yumi_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  error_cnt_o,
    output logic [count_width_p-1:0]  issued_cnt_o,
    output logic                      proto_err_o
);

    `DECLARE_TRACE_ENTRY_S(addr_width_p, data_width_p);
    `DECLARE_BSG_CACHE_PKT_S(addr_width_p, data_width_p);

    trace_entry_s       entry;
    bsg_cache_pkt_s     pkt;
    replay_state_e      state_q, state_d;

    logic                    fifo_ready, fifo_v, enq, deq;
    logic [data_width_p:0]   fifo_head;
    logic                    head_is_lm;
    logic [data_width_p-1:0] head_data;
    logic [count_width_p-1:0] err_cnt_q, issued_cnt_q;
    logic                    proto_err_q;

    assign entry = trace_entry_i;

    always_comb begin
        pkt        = '0;
        pkt.opcode = (entry.op == eLM) ? eCacheLW : eCacheSW;
        pkt.addr   = entry.addr;
        pkt.data   = entry.data;
        pkt.mask   = '1;
    end
    assign cache_pkt_o = pkt;

    always_comb begin
        state_d       = state_q;
        v_o           = 1'b0;
        trace_ready_o = 1'b0;
        enq           = 1'b0;
        unique case (state_q)
            eRun: begin
                if (trace_v_i) begin
                    unique case (entry.op)
                        eSM, eLM: begin
                            v_o           = fifo_ready;
                            trace_ready_o = fifo_ready & ready_i;
                            enq           = fifo_ready & ready_i;
                        end
                        eNop: trace_ready_o = 1'b1;
                        eFinish: begin
                            trace_ready_o = 1'b1;
                            state_d       = eDrain;
                        end
                        default: ;
                    endcase
                end
            end
            // A response in flight this cycle still has to be checked before we call it done.
            eDrain: if (!fifo_v && !v_i) state_d = eDone;
            eDone: ;
            default: state_d = eRun;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= eRun;
        else         state_q <= state_d;
    end

    bsg_fifo_1r1w_small #(
        .els_p   (max_out_p),
        .width_p (data_width_p + 1)
    ) expect_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq),
        .ready_o (fifo_ready),
        .data_i  ({entry.op == eLM, entry.data}),
        .v_o     (fifo_v),
        .data_o  (fifo_head),
        .yumi_i  (deq)
    );

    assign {head_is_lm, head_data} = fifo_head;
    assign yumi_o = v_i;
    assign deq    = v_i & fifo_v;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_q    <= '0;
            issued_cnt_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            if (enq && issued_cnt_q != '1) issued_cnt_q <= issued_cnt_q + 1'b1;
            if (deq && head_is_lm && data_i != head_data && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (v_i && !fifo_v) proto_err_q <= 1'b1;
        end
    end

    assign error_cnt_o  = err_cnt_q;
    assign issued_cnt_o = issued_cnt_q;
    assign proto_err_o  = proto_err_q;
    assign done_o       = (state_q == eDone);

endmodule

// File: tb/tb_bsg_manycore_vcache_trace_replayer.sv
// Self-checking bench: trace source, in-order cache emulator with a memory model, and a
// transaction-level expectation model compared against the replayer every cycle.
module tb_bsg_manycore_vcache_trace_replayer;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int CW = 4;
    localparam int EW = 2 + AW + DW;
    localparam int PW = 6 + AW + DW + DW / 8;
    localparam logic [5:0] OP_LW = 6'h02;
    localparam logic [5:0] OP_SW = 6'h0A;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [EW-1:0] trace_entry = '0;
    logic          trace_v = 1'b0;
    logic          trace_ready;
    logic [PW-1:0] cache_pkt;
    logic          pkt_v;
    logic          ready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rv = 1'b0;
    logic          yumi;
    logic          done;
    logic [CW-1:0] error_cnt, issued_cnt;
    logic          proto_err;

    always #5 clk = ~clk;

    bsg_manycore_vcache_trace_replayer #(
        .addr_width_p  (AW),
        .data_width_p  (DW),
        .max_out_p     (MO),
        .count_width_p (CW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .trace_entry_i (trace_entry),
        .trace_v_i     (trace_v),
        .trace_ready_o (trace_ready),
        .cache_pkt_o   (cache_pkt),
        .v_o           (pkt_v),
        .ready_i       (ready),
        .data_i        (rdata),
        .v_i           (rv),
        .yumi_o        (yumi),
        .done_o        (done),
        .error_cnt_o   (error_cnt),
        .issued_cnt_o  (issued_cnt),
        .proto_err_o   (proto_err)
    );

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        bit            bad;
    } resp_t;

    ent_t          trace_q[$];
    resp_t         pend_q[$];
    logic [DW-1:0] mem    [logic [AW-1:0]];
    logic [DW-1:0] shadow [logic [AW-1:0]];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: mode 0 = replaying, 1 = draining, 2 = done.
    int m_mode, m_issued, m_err;
    bit m_proto;

    int vld_pct = 100, ready_pct = 100, resp_pct = 100, lat_min = 1, lat_max = 1;
    int ready_lo_from = -1, ready_lo_to = -1;
    bit spurious = 0;
    int max_outst, done_cyc, vo_cnt, stall_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    // Called at a negedge: drive inputs, check outputs, advance model, move to next negedge.
    task automatic cycle();
        ent_t          e;
        resp_t         r;
        bit            ev, etr;
        int            n_out;
        logic [PW-1:0] epkt;

        n_out = pend_q.size();
        if (trace_q.size() > 0) begin
            e = trace_q[0];
            trace_v = ($urandom_range(99) < vld_pct);
        end else begin
            e.op = 2'($urandom_range(3));
            e.addr = AW'($urandom);
            e.data = $urandom;
            trace_v = 1'b0;
        end
        trace_entry = {e.op, e.addr, e.data};
        if (cyc >= ready_lo_from && cyc <= ready_lo_to) ready = 1'b0;
        else ready = ($urandom_range(99) < ready_pct);
        rv = (n_out > 0 && pend_q[0].due <= cyc && $urandom_range(99) < resp_pct)
             || (spurious && n_out == 0);
        rdata = (rv && n_out > 0) ? pend_q[0].data : $urandom;
        #1;

        ev = 0;
        etr = 0;
        if (m_mode == 0 && trace_v) begin
            if (e.op == 2'd1 || e.op == 2'd2) begin
                ev = (n_out < MO);
                etr = ev && ready;
            end else begin
                etr = 1;
            end
        end
        chk("v_o", pkt_v, ev);
        chk("trace_ready_o", trace_ready, etr);
        chk("yumi_o", yumi, rv);
        chk("done_o", done, m_mode == 2);
        chk("issued_cnt_o", issued_cnt, m_issued);
        chk("error_cnt_o", error_cnt, m_err);
        chk("proto_err_o", proto_err, m_proto);
        if (ev) begin
            epkt = {(e.op == 2'd2) ? OP_LW : OP_SW, e.addr, e.data, 4'hF};
            chk("cache_pkt_o", cache_pkt, epkt);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        if (pkt_v) vo_cnt++;
        if (!pkt_v && trace_v && (e.op == 2'd1 || e.op == 2'd2)) stall_cnt++;

        if (rv) begin
            if (n_out > 0) begin
                r = pend_q.pop_front();
                if (r.bad) m_err = sat_inc(m_err);
            end else begin
                m_proto = 1;
            end
        end
        if (m_mode == 1 && n_out == 0 && !rv) m_mode = 2;
        if (etr) begin
            void'(trace_q.pop_front());
            if (e.op == 2'd3) m_mode = 1;
            if (e.op == 2'd1 || e.op == 2'd2) begin
                m_issued = sat_inc(m_issued);
                r.due = cyc + $urandom_range(lat_max, lat_min);
                if (e.op == 2'd1) begin
                    mem[e.addr] = e.data;
                    r.data = $urandom;
                    r.bad = 0;
                end else begin
                    r.data = mem.exists(e.addr) ? mem[e.addr] : '0;
                    r.bad = (r.data != e.data);
                end
                pend_q.push_back(r);
                if (pend_q.size() > max_outst) max_outst = pend_q.size();
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trace_v = 1'b0;
        rv = 1'b0;
        ready = 1'b0;
        #1;
        chk("rst_done", done, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_err", error_cnt, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_v_o", pkt_v, 0);
        trace_q.delete();
        pend_q.delete();
        m_mode = 0;
        m_issued = 0;
        m_err = 0;
        m_proto = 0;
        max_outst = 0;
        done_cyc = -1;
        vo_cnt = 0;
        stall_cnt = 0;
        vld_pct = 100;
        ready_pct = 100;
        resp_pct = 100;
        lat_min = 1;
        lat_max = 1;
        ready_lo_from = -1;
        ready_lo_to = -1;
        spurious = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic push(input int op, input int addr, input logic [DW-1:0] data);
        ent_t e;
        e.op = 2'(op);
        e.addr = AW'(addr);
        e.data = data;
        trace_q.push_back(e);
    endtask

    task automatic run_until(input int mode, input int budget);
        int n = 0;
        while (m_mode < mode && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (m_mode < mode) begin
            failures++;
            $display("FAIL timeout: mode %0d required %0d after %0d cycles", m_mode, mode, n);
        end
    endtask

    initial begin
        @(negedge clk);

        // SM then LM of the same word, then FINISH.
        do_reset();
        push(1, 'h40, 5);
        push(2, 'h40, 5);
        push(3, 0, 0);
        run_until(2, 50);
        cycle();
        cycle();
        chk("t1_issued", issued_cnt, 2);
        chk("t1_err", error_cnt, 0);
        chk("t1_done", done, 1);

        // LM expecting 7 while memory holds 9.
        do_reset();
        mem['h80] = 9;
        push(2, 'h80, 7);
        push(3, 0, 0);
        run_until(2, 50);
        cycle();
        cycle();
        chk("t2_err", error_cnt, 1);
        chk("t2_done", done, 1);

        // Six back-to-back LMs against 10-cycle responses.
        do_reset();
        lat_min = 10;
        lat_max = 10;
        for (int i = 0; i < 6; i++) begin
            mem[AW'('h100 + 4 * i)] = 100 + i;
            push(2, 'h100 + 4 * i, 100 + i);
        end
        push(3, 0, 0);
        run_until(2, 200);
        cycle();
        cycle();
        chk("t3_max_outstanding", max_outst, 4);
        chk("t3_stalled", stall_cnt > 0, 1);
        chk("t3_issued", issued_cnt, 6);
        chk("t3_err", error_cnt, 0);
        chk("t3_proto", proto_err, 0);

        // Cache back-pressure for five cycles mid-trace.
        do_reset();
        ready_lo_from = 1;
        ready_lo_to = 5;
        for (int i = 0; i < 4; i++) push(1, 'h200 + 4 * i, 32'hA0 + i);
        push(3, 0, 0);
        run_until(2, 100);
        cycle();
        chk("t4_issued", issued_cnt, 4);

        // NOP, NOP, FINISH only.
        do_reset();
        push(0, 0, 0);
        push(0, 0, 0);
        push(3, 0, 0);
        run_until(2, 20);
        cycle();
        cycle();
        chk("t5_done_cycle", done_cyc, 4);
        chk("t5_v_o_count", vo_cnt, 0);

        // Spurious response at idle, then reset while draining.
        do_reset();
        spurious = 1;
        cycle();
        spurious = 0;
        cycle();
        chk("t6_proto", proto_err, 1);
        lat_min = 30;
        lat_max = 30;
        for (int i = 0; i < 3; i++) push(2, 'h300 + 4 * i, 0);
        push(3, 0, 0);
        run_until(1, 50);
        cycle();
        cycle();
        do_reset();
        push(0, 0, 0);
        push(3, 0, 0);
        run_until(2, 20);
        cycle();
        chk("t6_done_after_reset", done, 1);
        chk("t6_proto_cleared", proto_err, 0);

        // Randomized mix; 30 issues saturate the 4-bit issue counter.
        do_reset();
        vld_pct = 70;
        ready_pct = 60;
        resp_pct = 70;
        lat_min = 1;
        lat_max = 6;
        shadow = mem;
        for (int i = 0; i < 30; i++) begin
            int a;
            logic [DW-1:0] d;
            a = 4 * $urandom_range(7);
            if ($urandom_range(1) == 0) begin
                d = $urandom;
                shadow[AW'(a)] = d;
                push(1, a, d);
            end else begin
                d = (shadow.exists(AW'(a)) && $urandom_range(99) < 70) ? shadow[AW'(a)] : $urandom;
                push(2, a, d);
            end
            if ($urandom_range(3) == 0) push(0, 0, $urandom);
        end
        push(3, 0, 0);
        run_until(2, 2000);
        cycle();
        cycle();
        chk("t7_issued_saturated", issued_cnt, 15);
        chk("t7_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
